risc_ctrl_ws: RTL
=================

Name: risc_ctrl_ws

Overview:
- Second-generation instruction sequencer for the RISC CPU. Same 8-phase fetch/execute control as the current controller (rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel).
- Adds: parametrised opcode width, memory wait-states with a `mem_rdy` handshake, a wait-state timeout that raises a bus error, resumable HALT, and single-step debug mode.
- Sits between the instruction register/ALU zero flag and the datapath load/enable strobes.

Parameters:
- OP_W, 3, opcode width. Codes 0-7 are the ISA; codes >= 8 (OP_W > 3) decode as NOP.
- MAX_WAIT, 15, maximum consecutive wait cycles in one memory phase before `bus_err` (1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_  in  1  asynchronous active-low reset
- opcode  in  OP_W  current instruction opcode (from IR)
- zero  in  1  accumulator-zero flag
- mem_rdy  in  1  memory ready; low inserts wait states
- resume  in  1  1-cycle pulse; releases HALT
- step_en  in  1  single-step mode enable
- step  in  1  1-cycle pulse; runs one instruction in step mode
- rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel  out  1 each  datapath strobes
- bus_err  out  1  sticky wait-timeout error
- stalled  out  1  high while holding a phase (wait, halt, or step pause)
- phase  out  3  current phase P0..P7 (debug)

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-low (`rst_`).
- Reset state:
  - phase=P0; wcnt=0; bus_err=0; no HALT or error-halt condition.
  - Output values at reset: sel=1; all other strobes 0; stalled=0 (or 1 if step_en=1).
- Strobe decode:
  - Strobes are combinational from the phase register, opcode and zero.
  - aluop = ADD(2), AND(3), XOR(4), LDA(5).
- Per-phase strobes:
  - P0 INST_ADDR: sel
  - P1 INST_FETCH: sel, rd
  - P2 INST_LOAD: sel, rd, ld_ir
  - P3 IDLE: sel, rd, ld_ir
  - P4 OP_ADDR: inc_pc; halt = (opcode==HLT)
  - P5 OP_FETCH: rd = aluop
  - P6 ALU_OP: rd = aluop; inc_pc = (SKZ & zero); ld_pc = JMP; data_e = STO
  - P7 STORE: rd = aluop; ld_ac = aluop; ld_pc = JMP; wr = STO; data_e = STO
- Sequencing: phase advances by one per clock; P7 wraps to P0.
- NOP opcodes (>= 8): no rd, wr, ld_ac, ld_pc or data_e; only the P4 inc_pc.
- Wait states:
  - Apply in P2 always, and in P7 only when rd or wr is high.
  - If mem_rdy=0 at the edge, hold the phase, hold all strobes, increment wcnt, and set stalled=1.
  - wcnt clears on any phase advance.
  - mem_rdy is ignored in all other phases.
- Timeout:
  - If mem_rdy=0 at an edge where wcnt==MAX_WAIT-1: set bus_err=1 and enter error-halt.
  - Error-halt: phase frozen, all strobes 0 except halt=1, stalled=1.
  - Only reset exits error-halt; resume has no effect.
- HALT:
  - In P4 with opcode HLT, the phase holds at P4 with halt=1 and inc_pc=1 until resume is sampled high.
  - Datapath PC increment is gated by halt, so no repeated increment.
  - On resume: advance to P5 next cycle. HLT then has no further strobes; the sequence continues to P0.
  - resume outside HALT is ignored.
- Single-step:
  - With step_en=1, the sequencer holds in P0 (stalled=1) until step is sampled high, then runs exactly one instruction back to P0.
  - step pulses while not paused in P0 are ignored.
  - Clearing step_en while paused: advance on the next edge.
- Simultaneous events:
  - Wait and timeout take priority over everything.
  - HALT in step mode needs resume; the sequencer then pauses at P0 for the next step.
  - resume and step in the same cycle: each is applied only in its own holding phase.
- Reset mid-operation, any phase, wait or halt: immediately returns to the reset state.

Test Plan:
- Reset then opcode=LDA(5), mem_rdy=1 -> P0..P7 in 8 clocks. rd high in P1-P3 and P5-P7; ld_ir in P2-P3; ld_ac only in P7; the P0-P7 strobe vector matches the table above.
- opcode=SKZ, zero=1 -> inc_pc high in P4 and P6. With zero=0 -> inc_pc only in P4. JMP -> ld_pc in P6-P7. STO -> data_e in P6-P7 and wr in P7.
- mem_rdy=0 for 3 cycles in P2 -> phase stays P2 for 4 clocks with stalled=1; P3 follows the cycle mem_rdy=1 is sampled; bus_err stays 0.
- MAX_WAIT=15, mem_rdy held 0 in P7 during STO -> bus_err=1 on the 15th wait edge; halt=1, wr=0; resume has no effect; rst_ low clears bus_err, phase=P0, sel=1.
- opcode=HLT -> halt=1, phase held at P4 for 10 clocks; resume pulse -> P5 on the next edge, halt=0, next fetch begins at P0.
- step_en=1 -> phase held at P0. Two step pulses 20 clocks apart -> exactly two 8-phase instructions; stalled=1 between them; a step pulse during P3 is ignored.

Source files
------------

// File: rtl/risc_ctrl_ws.sv
// risc_ctrl_ws: 8-phase fetch/execute sequencer with memory wait-states,
// wait-timeout bus error, resumable HALT and single-step debug pause.
module risc_ctrl_ws #(
    parameter int OP_W     = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_rdy,
    input  logic            resume,
    input  logic            step_en,
    input  logic            step,
    output logic            rd,
    output logic            wr,
    output logic            ld_ir,
    output logic            ld_ac,
    output logic            ld_pc,
    output logic            inc_pc,
    output logic            halt,
    output logic            data_e,
    output logic            sel,
    output logic            bus_err,
    output logic            stalled,
    output logic [2:0]      phase
);

    typedef enum logic [2:0] {
        P0_INST_ADDR  = 3'd0,
        P1_INST_FETCH = 3'd1,
        P2_INST_LOAD  = 3'd2,
        P3_IDLE       = 3'd3,
        P4_OP_ADDR    = 3'd4,
        P5_OP_FETCH   = 3'd5,
        P6_ALU_OP     = 3'd6,
        P7_STORE      = 3'd7
    } phase_e;

    localparam logic [OP_W-1:0] OP_HLT = OP_W'(3'd0);
    localparam logic [OP_W-1:0] OP_SKZ = OP_W'(3'd1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'd2);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3'd3);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(3'd4);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(3'd5);
    localparam logic [OP_W-1:0] OP_STO = OP_W'(3'd6);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(3'd7);
    localparam logic [7:0]      WAIT_LAST = 8'(MAX_WAIT - 1);

    phase_e     phase_r;
    phase_e     phase_nxt_s;
    logic [7:0] wcnt_r;
    logic [7:0] wcnt_nxt_s;
    logic       bus_err_r;
    logic       err_nxt_s;
    logic       hold_s;

    logic is_hlt_s;
    logic is_skz_s;
    logic is_alu_s;
    logic is_sto_s;
    logic is_jmp_s;
    logic wait_phase_s;

    // Codes above 7 match none of these and therefore behave as NOP.
    assign is_hlt_s = (opcode == OP_HLT);
    assign is_skz_s = (opcode == OP_SKZ);
    assign is_alu_s = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto_s = (opcode == OP_STO);
    assign is_jmp_s = (opcode == OP_JMP);

    // P7 only touches memory when it reads an operand or writes the accumulator.
    assign wait_phase_s = (phase_r == P2_INST_LOAD) ||
                          ((phase_r == P7_STORE) && (is_alu_s || is_sto_s));

    // State register: phase, wait counter and sticky bus error.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_r   <= P0_INST_ADDR;
            wcnt_r    <= 8'd0;
            bus_err_r <= 1'b0;
        end else begin
            phase_r   <= phase_nxt_s;
            wcnt_r    <= wcnt_nxt_s;
            bus_err_r <= err_nxt_s;
        end
    end

    // Next-state: wait/timeout first, then HALT hold, then step pause, else advance.
    always_comb begin
        phase_nxt_s = phase_r;
        wcnt_nxt_s  = wcnt_r;
        err_nxt_s   = bus_err_r;
        hold_s      = 1'b1;
        if (bus_err_r) begin
            phase_nxt_s = phase_r;
        end else if (wait_phase_s && !mem_rdy) begin
            if (wcnt_r == WAIT_LAST) begin
                err_nxt_s = 1'b1;
            end else begin
                wcnt_nxt_s = wcnt_r + 8'd1;
            end
        end else if ((phase_r == P4_OP_ADDR) && is_hlt_s && !resume) begin
            phase_nxt_s = phase_r;
        end else if ((phase_r == P0_INST_ADDR) && step_en && !step) begin
            phase_nxt_s = phase_r;
        end else begin
            phase_nxt_s = phase_e'(phase_r + 3'd1);
            wcnt_nxt_s  = 8'd0;
            hold_s      = 1'b0;
        end
    end

    // Datapath strobes decoded from the current phase, opcode and zero flag.
    always_comb begin
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        sel    = 1'b0;
        if (bus_err_r) begin
            halt = 1'b1;
        end else begin
            case (phase_r)
                P0_INST_ADDR: begin
                    sel = 1'b1;
                end
                P1_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                P2_INST_LOAD, P3_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                P4_OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt_s;
                end
                P5_OP_FETCH: begin
                    rd = is_alu_s;
                end
                P6_ALU_OP: begin
                    rd     = is_alu_s;
                    inc_pc = is_skz_s & zero;
                    ld_pc  = is_jmp_s;
                    data_e = is_sto_s;
                end
                P7_STORE: begin
                    rd     = is_alu_s;
                    ld_ac  = is_alu_s;
                    ld_pc  = is_jmp_s;
                    wr     = is_sto_s;
                    data_e = is_sto_s;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

    assign bus_err = bus_err_r;
    assign stalled = hold_s;
    assign phase   = phase_r;

endmodule
